// File: rtl/uart_cmd_link_if.sv
// Command-processor side of the UART command link: assembled commands in,
// response bytes out.
interface uart_cmd_link_if;
    logic [15:0] cmd;
    logic        cmd_rdy;
    logic        clr_cmd_rdy;
    logic [7:0]  resp;
    logic        trmt;
    logic        tx_done;
    logic        overrun;

    modport master (
        output clr_cmd_rdy, resp, trmt,
        input  cmd, cmd_rdy, tx_done, overrun
    );

    modport slave (
        input  clr_cmd_rdy, resp, trmt,
        output cmd, cmd_rdy, tx_done, overrun
    );
endinterface

// File: rtl/uart_cmd_link.sv
// 8N1 UART front end: packs received byte pairs (high byte first) into 16-bit
// commands and serialises 8-bit responses onto TX.
//
// state    | meaning
// RX_IDLE  | waiting for a falling edge on synced RX
// RX_START | half-bit wait, confirm start bit is still low
// RX_DATA  | sampling 8 data bits LSB first, one per bit period
// RX_STOP  | sampling stop bit; high = valid byte, low = framing error
// WAIT_HI  | assembler expects the high byte
// WAIT_LO  | high byte held, timeout running while receiver is idle
// TX_IDLE  | line high, ready to accept trmt
// TX_XMIT  | shifting out a 10-bit frame
module uart_cmd_link #(
    parameter int BAUD_DIV = 2604,
    parameter int TIMEOUT  = 1_000_000
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            RX,
    output logic            TX,
    uart_cmd_link_if.slave  cpu
);

    localparam int BW = ($clog2(BAUD_DIV) > 12) ? $clog2(BAUD_DIV) : 12;
    localparam int TW = ($clog2(TIMEOUT + 1) > 20) ? $clog2(TIMEOUT + 1) : 20;

    localparam logic [BW-1:0] BIT_LD  = BW'(BAUD_DIV - 1);
    localparam logic [BW-1:0] HALF_LD = BW'(BAUD_DIV / 2 - 1);
    localparam logic [BW-1:0] BW_ONE  = BW'(1);
    localparam logic [TW-1:0] TMO_LD  = TW'(TIMEOUT);
    localparam logic [TW-1:0] TW_ONE  = TW'(1);

    typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;
    typedef enum logic       {WAIT_HI, WAIT_LO}                    asm_state_t;
    typedef enum logic       {TX_IDLE, TX_XMIT}                    tx_state_t;

    // Synchroniser resets low so a start bit already in progress at reset
    // release never looks like a fresh falling edge.
    logic rx_meta, rx_sync, rx_prev;
    logic rx_fall;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_meta <= 1'b0;
            rx_sync <= 1'b0;
            rx_prev <= 1'b0;
        end else begin
            rx_meta <= RX;
            rx_sync <= rx_meta;
            rx_prev <= rx_sync;
        end
    end

    assign rx_fall = rx_prev & ~rx_sync;

    rx_state_t       rx_state, rx_state_nxt;
    logic [BW-1:0]   rx_cnt, rx_cnt_nxt;
    logic [2:0]      rx_idx, rx_idx_nxt;
    logic [7:0]      rx_shift, rx_shift_nxt;
    logic            byte_vld;
    logic            frame_err;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_state <= RX_IDLE;
            rx_cnt   <= '0;
            rx_idx   <= '0;
            rx_shift <= '0;
        end else begin
            rx_state <= rx_state_nxt;
            rx_cnt   <= rx_cnt_nxt;
            rx_idx   <= rx_idx_nxt;
            rx_shift <= rx_shift_nxt;
        end
    end

    always_comb begin
        rx_state_nxt = rx_state;
        rx_cnt_nxt   = rx_cnt;
        rx_idx_nxt   = rx_idx;
        rx_shift_nxt = rx_shift;
        byte_vld     = 1'b0;
        frame_err    = 1'b0;
        case (rx_state)
            RX_IDLE: begin
                if (rx_fall) begin
                    rx_state_nxt = RX_START;
                    rx_cnt_nxt   = HALF_LD;
                end
            end
            RX_START: begin
                if (rx_cnt == '0) begin
                    if (rx_sync) begin
                        rx_state_nxt = RX_IDLE;
                    end else begin
                        rx_state_nxt = RX_DATA;
                        rx_cnt_nxt   = BIT_LD;
                        rx_idx_nxt   = '0;
                    end
                end else begin
                    rx_cnt_nxt = rx_cnt - BW_ONE;
                end
            end
            RX_DATA: begin
                if (rx_cnt == '0) begin
                    rx_shift_nxt = {rx_sync, rx_shift[7:1]};
                    rx_cnt_nxt   = BIT_LD;
                    if (rx_idx == 3'd7) begin
                        rx_state_nxt = RX_STOP;
                    end else begin
                        rx_idx_nxt = rx_idx + 3'd1;
                    end
                end else begin
                    rx_cnt_nxt = rx_cnt - BW_ONE;
                end
            end
            RX_STOP: begin
                if (rx_cnt == '0) begin
                    rx_state_nxt = RX_IDLE;
                    byte_vld     = rx_sync;
                    frame_err    = ~rx_sync;
                end else begin
                    rx_cnt_nxt = rx_cnt - BW_ONE;
                end
            end
            default: rx_state_nxt = RX_IDLE;
        endcase
    end

    asm_state_t      asm_state, asm_state_nxt;
    logic [7:0]      hi_byte, hi_byte_nxt;
    logic [TW-1:0]   tmo_cnt, tmo_cnt_nxt;
    logic            cmd_done;
    logic [15:0]     cmd_q;
    logic            cmd_rdy_q;
    logic            overrun_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            asm_state <= WAIT_HI;
            hi_byte   <= '0;
            tmo_cnt   <= '0;
            cmd_q     <= '0;
            cmd_rdy_q <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            asm_state <= asm_state_nxt;
            hi_byte   <= hi_byte_nxt;
            tmo_cnt   <= tmo_cnt_nxt;
            if (cmd_done) begin
                cmd_q <= {hi_byte, rx_shift};
            end
            // completion wins over a coincident clear
            cmd_rdy_q <= cmd_done | (cmd_rdy_q & ~cpu.clr_cmd_rdy);
            overrun_q <= cmd_done & cmd_rdy_q;
        end
    end

    always_comb begin
        asm_state_nxt = asm_state;
        hi_byte_nxt   = hi_byte;
        tmo_cnt_nxt   = tmo_cnt;
        cmd_done      = 1'b0;
        case (asm_state)
            WAIT_HI: begin
                if (byte_vld) begin
                    hi_byte_nxt   = rx_shift;
                    tmo_cnt_nxt   = TMO_LD;
                    asm_state_nxt = WAIT_LO;
                end
            end
            WAIT_LO: begin
                if (byte_vld) begin
                    cmd_done      = 1'b1;
                    asm_state_nxt = WAIT_HI;
                end else if (frame_err) begin
                    asm_state_nxt = WAIT_HI;
                end else if (rx_state == RX_IDLE) begin
                    // down-counter holds at zero rather than wrapping
                    if (tmo_cnt == '0) begin
                        asm_state_nxt = WAIT_HI;
                    end else begin
                        tmo_cnt_nxt = tmo_cnt - TW_ONE;
                    end
                end
            end
            default: asm_state_nxt = WAIT_HI;
        endcase
    end

    assign cpu.cmd     = cmd_q;
    assign cpu.cmd_rdy = cmd_rdy_q;
    assign cpu.overrun = overrun_q;

    tx_state_t       tx_state, tx_state_nxt;
    logic [BW-1:0]   tx_cnt, tx_cnt_nxt;
    logic [3:0]      tx_bits, tx_bits_nxt;
    logic [9:0]      tx_shift, tx_shift_nxt;
    logic            tx_done_q, tx_done_nxt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tx_state  <= TX_IDLE;
            tx_cnt    <= '0;
            tx_bits   <= '0;
            tx_shift  <= '1;
            tx_done_q <= 1'b0;
        end else begin
            tx_state  <= tx_state_nxt;
            tx_cnt    <= tx_cnt_nxt;
            tx_bits   <= tx_bits_nxt;
            tx_shift  <= tx_shift_nxt;
            tx_done_q <= tx_done_nxt;
        end
    end

    always_comb begin
        tx_state_nxt = tx_state;
        tx_cnt_nxt   = tx_cnt;
        tx_bits_nxt  = tx_bits;
        tx_shift_nxt = tx_shift;
        tx_done_nxt  = tx_done_q;
        case (tx_state)
            TX_IDLE: begin
                if (cpu.trmt) begin
                    tx_shift_nxt = {1'b1, cpu.resp, 1'b0};
                    tx_cnt_nxt   = BIT_LD;
                    tx_bits_nxt  = '0;
                    tx_done_nxt  = 1'b0;
                    tx_state_nxt = TX_XMIT;
                end
            end
            TX_XMIT: begin
                if (tx_cnt == '0) begin
                    tx_shift_nxt = {1'b1, tx_shift[9:1]};
                    tx_cnt_nxt   = BIT_LD;
                    if (tx_bits == 4'd9) begin
                        tx_done_nxt  = 1'b1;
                        tx_state_nxt = TX_IDLE;
                    end else begin
                        tx_bits_nxt = tx_bits + 4'd1;
                    end
                end else begin
                    tx_cnt_nxt = tx_cnt - BW_ONE;
                end
            end
            default: tx_state_nxt = TX_IDLE;
        endcase
    end

    assign TX          = tx_shift[0];
    assign cpu.tx_done = tx_done_q;

endmodule

// File: tb/tb_uart_cmd_link.sv
// Directed bench for uart_cmd_link at a shortened bit period so whole
// command/response sequences fit in a few thousand clocks.
module tb_uart_cmd_link;

    localparam int B   = 16;
    localparam int TMO = 500;
    // Start edge at negedge n=0: 2 sync flops + edge-detect register, then
    // half a bit, 8 data bits and the stop bit; the completing edge follows
    // the negedge at n = 9.5*B + 2.
    localparam int CLR_SIM = 9 * B + B / 2 + 2;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic RX = 1'b1;
    logic TX;

    int n_chk = 0;
    int n_err = 0;
    int ovr_cnt = 0;

    uart_cmd_link_if cpu_if ();

    uart_cmd_link #(.BAUD_DIV(B), .TIMEOUT(TMO)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .RX    (RX),
        .TX    (TX),
        .cpu   (cpu_if)
    );

    always #5 clk = ~clk;

    always @(negedge clk) if (cpu_if.overrun === 1'b1) ovr_cnt++;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send_frame(input logic [7:0] data, input logic stop,
                              input int clr_at, input int rst_at, input int rls_at);
        logic [9:0] fr;
        fr = {stop, data, 1'b0};
        for (int n = 0; n < 10 * B; n++) begin
            @(negedge clk);
            RX = fr[n / B];
            cpu_if.clr_cmd_rdy = (n == clr_at);
            if (n == rst_at) rst_n = 1'b0;
            if (n == rls_at) rst_n = 1'b1;
        end
        @(negedge clk);
        RX = 1'b1;
        cpu_if.clr_cmd_rdy = 1'b0;
    endtask

    task automatic send_cmd(input logic [7:0] hi, input logic [7:0] lo);
        send_frame(hi, 1'b1, -1, -1, -1);
        idle(B);
        send_frame(lo, 1'b1, -1, -1, -1);
        idle(2);
    endtask

    task automatic wait_rdy(input string tag);
        int k;
        k = 0;
        while (cpu_if.cmd_rdy !== 1'b1 && k < 4 * B) begin
            @(negedge clk);
            k++;
        end
        chk(tag, cpu_if.cmd_rdy, 1);
    endtask

    task automatic clear_rdy(input string tag);
        @(negedge clk);
        cpu_if.clr_cmd_rdy = 1'b1;
        @(negedge clk);
        cpu_if.clr_cmd_rdy = 1'b0;
        chk(tag, cpu_if.cmd_rdy, 0);
    endtask

    initial begin
        logic [9:0] tfr;
        logic       exp_bit;
        int         tx_bad;
        int         j_done;
        int         ovr0;

        cpu_if.clr_cmd_rdy = 1'b0;
        cpu_if.resp        = 8'h00;
        cpu_if.trmt        = 1'b0;
        idle(3);
        chk("rst_tx", TX, 1);
        chk("rst_cmd", cpu_if.cmd, 16'h0000);
        chk("rst_rdy", cpu_if.cmd_rdy, 0);
        chk("rst_done", cpu_if.tx_done, 0);
        chk("rst_ovr", cpu_if.overrun, 0);
        rst_n = 1'b1;
        idle(5);

        // calibrate command
        send_cmd(8'h20, 8'h00);
        wait_rdy("cal_rdy");
        chk("cal_cmd", cpu_if.cmd, 16'h2000);
        clear_rdy("cal_clr");

        // ack response with a second trmt mid-frame
        @(negedge clk);
        cpu_if.resp = 8'hA5;
        cpu_if.trmt = 1'b1;
        tfr    = {1'b1, 8'hA5, 1'b0};
        tx_bad = 0;
        j_done = 0;
        for (int j = 1; j <= 10 * B + 2; j++) begin
            @(negedge clk);
            cpu_if.trmt = (j == 3 * B);
            if (j == 3 * B) cpu_if.resp = 8'h00;
            exp_bit = (j <= 10 * B) ? tfr[(j - 1) / B] : 1'b1;
            if (TX !== exp_bit) tx_bad++;
            if (j <= 10 * B && ((j - 1) % B) == B / 2)
                chk($sformatf("tx_bit%0d", (j - 1) / B), TX, exp_bit);
            if (cpu_if.tx_done === 1'b1 && j_done == 0) j_done = j;
        end
        chk("tx_wave", tx_bad, 0);
        chk("tx_done_at", j_done, 10 * B + 1);

        // high byte times out, later pair assembles cleanly
        send_frame(8'h21, 1'b1, -1, -1, -1);
        idle(TMO + 200);
        send_frame(8'h34, 1'b1, -1, -1, -1);
        idle(B);
        chk("tmo_hi_dropped", cpu_if.cmd_rdy, 0);
        send_frame(8'h56, 1'b1, -1, -1, -1);
        idle(2);
        wait_rdy("tmo_rdy");
        chk("tmo_cmd", cpu_if.cmd, 16'h3456);
        clear_rdy("tmo_clr");

        // framing error on low byte returns assembler to WAIT_HI
        send_frame(8'h12, 1'b1, -1, -1, -1);
        idle(B);
        send_frame(8'h34, 1'b0, -1, -1, -1);
        idle(B);
        chk("frm_no_rdy", cpu_if.cmd_rdy, 0);
        send_cmd(8'h56, 8'h78);
        wait_rdy("frm_rdy");
        chk("frm_cmd", cpu_if.cmd, 16'h5678);
        clear_rdy("frm_clr");

        // short low glitch shorter than half a bit
        @(negedge clk);
        RX = 1'b0;
        idle(5);
        RX = 1'b1;
        idle(2 * B);
        chk("glitch_no_rdy", cpu_if.cmd_rdy, 0);
        send_cmd(8'h9A, 8'hBC);
        wait_rdy("glitch_rdy");
        chk("glitch_cmd", cpu_if.cmd, 16'h9ABC);
        clear_rdy("glitch_clr");

        // overrun
        ovr0 = ovr_cnt;
        send_cmd(8'h4C, 8'h00);
        wait_rdy("ovr_rdy1");
        chk("ovr_cmd1", cpu_if.cmd, 16'h4C00);
        send_cmd(8'h4C, 8'h1F);
        chk("ovr_cmd2", cpu_if.cmd, 16'h4C1F);
        chk("ovr_rdy2", cpu_if.cmd_rdy, 1);
        chk("ovr_pulses", ovr_cnt - ovr0, 1);

        // clear coincident with completion
        send_frame(8'h11, 1'b1, -1, -1, -1);
        idle(B);
        send_frame(8'h22, 1'b1, CLR_SIM, -1, -1);
        idle(2);
        chk("simul_rdy", cpu_if.cmd_rdy, 1);
        chk("simul_cmd", cpu_if.cmd, 16'h1122);

        // reset during bit 4 of the low byte while TX is mid-frame
        send_frame(8'h20, 1'b1, -1, -1, -1);
        idle(B - 2);
        @(negedge clk);
        cpu_if.resp = 8'h0F;
        cpu_if.trmt = 1'b1;
        @(negedge clk);
        cpu_if.trmt = 1'b0;
        chk("tx_done_clr", cpu_if.tx_done, 0);
        send_frame(8'h00, 1'b1, -1, 5 * B + B / 2, -1);
        idle(2);
        chk("mid_rst_tx", TX, 1);
        chk("mid_rst_cmd", cpu_if.cmd, 16'h0000);
        chk("mid_rst_rdy", cpu_if.cmd_rdy, 0);
        chk("mid_rst_done", cpu_if.tx_done, 0);
        chk("mid_rst_ovr", cpu_if.overrun, 0);

        // release during a start bit: that byte must be ignored
        send_frame(8'hFF, 1'b1, -1, -1, B / 2);
        idle(B);
        chk("rls_no_rdy", cpu_if.cmd_rdy, 0);
        send_cmd(8'h20, 8'h00);
        wait_rdy("post_rst_rdy");
        chk("post_rst_cmd", cpu_if.cmd, 16'h2000);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
